// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus downstream valid/ready
// output. The master modport is the fetch unit; the slave modport is the side that
// owns the memory and consumes fetched instructions.
//   imem_addr   word address to memory read port (combinational from fetch unit)
//   imem_data   memory read data, one cycle after imem_addr
//   redirect    load redirect_pc as the new fetch PC this cycle
//   redirect_pc target byte PC (bits[1:0] ignored)
//   out_valid   out_pc/out_ir carry a valid instruction
//   out_ready   downstream accepts this cycle
//   out_pc      byte PC of out_ir
//   out_ir      instruction word
interface ifetch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [31:0]      imem_addr;
  logic [WIDTH-1:0] imem_data;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [WIDTH-1:0] out_ir;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_ir
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_ir
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage. Owns the PC, drives the read port of the instruction
// memory (1-cycle latency) and hands {pc, instruction} downstream over valid/ready.
// Two-deep pipeline: F1 = read in flight, D = registered output. During a stall the
// memory is re-addressed with the stalled F1 word, so imem_data stays valid for F1
// without a skid buffer. Redirects squash both F1 and D.
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset
//   bus   ifetch_unit_if master: imem_addr/imem_data, redirect/redirect_pc,
//         out_valid/out_ready/out_pc/out_ir
module ifetch_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);

  localparam logic [31:0] PC_MASK        = ~32'h3;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] RESET_PC_ALIGN = RESET_PC & PC_MASK;

  logic [31:0]      fetch_pc, fetch_pc_n;
  logic             req_valid, req_valid_n;
  logic [31:0]      req_pc, req_pc_n;
  logic             out_valid, out_valid_n;
  logic [31:0]      out_pc, out_pc_n;
  logic [WIDTH-1:0] out_ir, out_ir_n;

  logic             advance_c;
  logic             issue_c;
  logic [31:0]      redirect_align_c;
  logic [31:0]      addr_pc_c;

  // Pipeline control: F1 drains into D when D is empty or being accepted; a new
  // fetch issues unless the whole pipe is backed up.
  assign advance_c        = req_valid & (~out_valid | bus.out_ready);
  assign issue_c          = ~bus.redirect & (~req_valid | ~out_valid | bus.out_ready);
  assign redirect_align_c = bus.redirect_pc & PC_MASK;

  // Memory address: redirect target, else next PC, else replay the stalled F1 word.
  always_comb begin
    addr_pc_c = req_pc;
    if (bus.redirect) begin
      addr_pc_c = bus.redirect_pc;
    end else if (issue_c) begin
      addr_pc_c = fetch_pc;
    end
  end

  assign bus.imem_addr = addr_pc_c >> 2;

  // Next-state logic for PC, F1 and D slots.
  always_comb begin
    fetch_pc_n  = fetch_pc;
    req_valid_n = req_valid;
    req_pc_n    = req_pc;
    out_valid_n = out_valid;
    out_pc_n    = out_pc;
    out_ir_n    = out_ir;
    if (bus.redirect) begin
      // Squash: D dropped even if out_ready is high; target goes straight into F1.
      out_valid_n = 1'b0;
      req_valid_n = 1'b1;
      req_pc_n    = redirect_align_c;
      fetch_pc_n  = redirect_align_c + PC_STEP;
    end else begin
      if (advance_c) begin
        out_valid_n = 1'b1;
        out_pc_n    = req_pc;
        out_ir_n    = bus.imem_data;
      end else if (bus.out_ready) begin
        out_valid_n = 1'b0;
      end
      if (issue_c) begin
        req_valid_n = 1'b1;
        req_pc_n    = fetch_pc;
        fetch_pc_n  = fetch_pc + PC_STEP;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC_ALIGN;
      req_valid <= 1'b0;
      req_pc    <= 32'h0;
      out_valid <= 1'b0;
      out_pc    <= 32'h0;
      out_ir    <= WIDTH'(0);
    end else begin
      fetch_pc  <= fetch_pc_n;
      req_valid <= req_valid_n;
      req_pc    <= req_pc_n;
      out_valid <= out_valid_n;
      out_pc    <= out_pc_n;
      out_ir    <= out_ir_n;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_pc;
  assign bus.out_ir    = out_ir;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: synchronous-read memory with mem[w] = 0xA000_0000 + w,
// directed sequences with literal expectations, then randomized ready/redirect/reset
// traffic checked every cycle against a stream-level model of the fetch stage.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifetch_unit_if #(.WIDTH(32)) bus ();

  ifetch_unit #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    return 32'hA000_0000 + waddr;
  endfunction

  // Instruction memory read port, latency 1.
  always @(posedge clk) bus.imem_data <= mem_word(bus.imem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Stream model: exp_pc is the PC the output must present next; out_valid must be
  // high from 'lat' cycles after the last restart (3 after reset, 2 after redirect).
  logic [31:0] exp_pc  = 32'h0;
  int          age     = 0;
  int          lat     = 3;
  bit          started = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(bus.out_valid), 32'(age >= lat));
      if (age >= lat) begin
        chk("out_pc", bus.out_pc, exp_pc);
        chk("out_ir", bus.out_ir, mem_word(exp_pc >> 2));
      end
      if (!rst && bus.redirect)
        chk("addr_redirect", bus.imem_addr, bus.redirect_pc >> 2);
      else if (!rst && age >= lat && bus.out_valid && !bus.out_ready)
        chk("addr_replay", bus.imem_addr, (exp_pc + 32'd4) >> 2);
    end
    if (rst) begin
      exp_pc  = RESET_PC & ~32'h3;
      age     = 1;
      lat     = 3;
      started = 1'b1;
    end else if (bus.redirect) begin
      exp_pc = bus.redirect_pc & ~32'h3;
      age    = 1;
      lat    = 2;
    end else begin
      if (bus.out_valid && bus.out_ready) exp_pc = exp_pc + 32'd4;
      if (age < 100) age++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic valid, input logic [31:0] pc,
                     input logic [31:0] ir);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(valid));
    chk({name, "_pc"}, bus.out_pc, pc);
    chk({name, "_ir"}, bus.out_ir, ir);
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b1;
    rst             = 1'b1;
    repeat (3) step();
    lit("reset", 1'b0, 32'h0, 32'h0);

    // Streaming from RESET_PC, valid two cycles after release.
    rst = 1'b0;
    step();
    chk("lat1_valid", 32'(bus.out_valid), 32'h0);
    step();
    lit("first", 1'b1, 32'h100, 32'hA000_0040);
    step();
    lit("second", 1'b1, 32'h104, 32'hA000_0041);

    // Unaligned redirect target.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    step();
    bus.redirect = 1'b0;
    chk("redir_bubble", 32'(bus.out_valid), 32'h0);
    step();
    lit("redir_tgt", 1'b1, 32'h200, 32'hA000_0080);
    step();
    lit("redir_next", 1'b1, 32'h204, 32'hA000_0081);

    // PC wrap at the top of the address space.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    step();
    lit("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'hDFFF_FFFF);
    step();
    lit("wrap_zero", 1'b1, 32'h0, 32'hA000_0000);

    // Reset mid-stream with a redirect asserted alongside it.
    rst             = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0300;
    step();
    rst          = 1'b0;
    bus.redirect = 1'b0;
    chk("rst_valid1", 32'(bus.out_valid), 32'h0);
    step();
    chk("rst_valid2", 32'(bus.out_valid), 32'h0);
    step();
    lit("rst_refetch", 1'b1, 32'h100, 32'hA000_0040);

    // Three-cycle stall: output frozen, memory replays the F1 word.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      lit("stall", 1'b1, 32'h100, 32'hA000_0040);
      chk("stall_addr", bus.imem_addr, 32'h0000_0041);
    end
    bus.out_ready = 1'b1;
    step();
    lit("unstall", 1'b1, 32'h104, 32'hA000_0041);

    // Redirect while holding an unaccepted instruction.
    bus.out_ready = 1'b0;
    step();
    lit("held", 1'b1, 32'h104, 32'hA000_0041);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0400;
    bus.out_ready   = 1'b1;
    step();
    bus.redirect = 1'b0;
    chk("held_drop", 32'(bus.out_valid), 32'h0);
    step();
    lit("held_tgt", 1'b1, 32'h400, 32'hA000_0100);

    // Randomized traffic against the stream model.
    for (int c = 0; c < 4000; c++) begin
      bus.out_ready = ($urandom_range(3) != 0);
      bus.redirect  = ($urandom_range(19) == 0);
      if ($urandom_range(3) == 0)
        bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else
        bus.redirect_pc = $urandom;
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst          = 1'b0;
    bus.redirect = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
